// File: rtl/reward_calc_pkg.sv
// reward_calc_pkg: shared widths, node-state memory map, FSM encoding and address helper
package reward_calc_pkg;
  localparam int WORD_WIDTH = 16;
  localparam int ADDR_WIDTH = 11;
  localparam logic [ADDR_WIDTH-1:0] FLAGS_BASE = 11'h000;
  localparam logic [ADDR_WIDTH-1:0] NEIGHBOR_ID_BASE = 11'h048;
  localparam logic [ADDR_WIDTH-1:0] CLUSTER_ID_BASE = 11'h0C8;
  localparam logic [ADDR_WIDTH-1:0] BATTERY_BASE = 11'h148;
  localparam logic [ADDR_WIDTH-1:0] QVALUE_BASE = 11'h1C8;
  localparam logic [ADDR_WIDTH-1:0] NEIGHBOR_COUNT_ADDR = 11'h68A;
  localparam logic [ADDR_WIDTH-1:0] SINK_ID_COUNT_ADDR = 11'h68E;
  typedef enum logic [3:0] {
    IDLE, CNT_A, CNT_D, NID_A, NID_D, CID_A, CID_D, BAT_A, BAT_D, Q_A, Q_D, CALC, DONE
  } state_t;
  function automatic logic [ADDR_WIDTH-1:0] idx_addr(input logic [ADDR_WIDTH-1:0] base,
                                                     input logic [ADDR_WIDTH-2:0] idx);
    return base + {idx, 1'b0};
  endfunction
endpackage

// File: rtl/reward_adder.sv
// reward_adder: saturating sum of base reward, bonuses and battery term (plus qValue/4 under REWARD_QVAL_EN)
module reward_adder
  import reward_calc_pkg::*;
#(
  parameter logic [WORD_WIDTH-1:0] R_BASE = 16'd10,
  parameter logic [WORD_WIDTH-1:0] BEST_BONUS = 16'd50,
  parameter logic [WORD_WIDTH-1:0] CLUSTER_BONUS = 16'd20,
  parameter int BATT_SHIFT = 4
) (
  input logic is_best,
  input logic cluster_match,
  input logic [WORD_WIDTH-1:0] batt,
`ifdef REWARD_QVAL_EN
  input logic [WORD_WIDTH-1:0] qval,
`endif
  output logic [WORD_WIDTH-1:0] reward
);
  localparam int SW = WORD_WIDTH + 2;
  logic [SW-1:0] sum;
  always_comb begin
    sum = SW'(R_BASE)
        + (is_best ? SW'(BEST_BONUS) : SW'(0))
        + (cluster_match ? SW'(CLUSTER_BONUS) : SW'(0))
        + SW'(batt >> BATT_SHIFT)
`ifdef REWARD_QVAL_EN
        + SW'(qval >> 2)
`endif
        ;
    reward = |sum[SW-1:WORD_WIDTH] ? '1 : sum[WORD_WIDTH-1:0];
  end
endmodule

// File: rtl/reward_calc.sv
// reward_calc: fetches neighbor state from node memory and computes the Q-routing reward (REWARD_QVAL_EN adds qValue term)
module reward_calc
  import reward_calc_pkg::*;
#(
  parameter logic [WORD_WIDTH-1:0] R_BASE = 16'd10,
  parameter logic [WORD_WIDTH-1:0] BEST_BONUS = 16'd50,
  parameter logic [WORD_WIDTH-1:0] CLUSTER_BONUS = 16'd20,
  parameter int BATT_SHIFT = 4
) (
  input logic clock,
  input logic rst,
  input logic en,
  input logic start,
  input logic [WORD_WIDTH-1:0] MY_NODE_ID,
  input logic [WORD_WIDTH-1:0] MY_CLUSTER_ID,
  input logic [WORD_WIDTH-1:0] action,
  input logic [WORD_WIDTH-1:0] besthop,
  output logic [ADDR_WIDTH-1:0] address,
  input logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] reward_out,
  output logic done
);
  state_t state, state_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [WORD_WIDTH-1:0] reward_d, sum_reward;
  logic [WORD_WIDTH-1:0] node_id, cluster_id, act, best, nbr_id, nbr_cid, batt;
  logic done_d, load, invalid, invalid_d, out_of_range;
`ifdef REWARD_QVAL_EN
  logic [WORD_WIDTH-1:0] qval;
`endif
  assign out_of_range = act >= data_in;
  reward_adder #(
    .R_BASE(R_BASE),
    .BEST_BONUS(BEST_BONUS),
    .CLUSTER_BONUS(CLUSTER_BONUS),
    .BATT_SHIFT(BATT_SHIFT)
  ) u_adder (
    .is_best(act == best),
    .cluster_match(nbr_cid == cluster_id),
    .batt(batt),
`ifdef REWARD_QVAL_EN
    .qval(qval),
`endif
    .reward(sum_reward)
  );
  always_comb begin
    state_d = state;
    addr_d = address;
    reward_d = reward_out;
    done_d = done;
    invalid_d = invalid;
    load = 1'b0;
    case (state)
      IDLE: begin
        load = en;
        state_d = start ? CNT_A : IDLE;
        addr_d = start ? NEIGHBOR_COUNT_ADDR : address;
        invalid_d = start ? 1'b0 : invalid;
      end
      CNT_A: state_d = CNT_D;
      CNT_D: begin
        invalid_d = out_of_range;
        state_d = out_of_range ? CALC : NID_A;
        addr_d = out_of_range ? address : idx_addr(NEIGHBOR_ID_BASE, act[ADDR_WIDTH-2:0]);
      end
      NID_A: state_d = NID_D;
      NID_D: begin
        state_d = CID_A;
        addr_d = idx_addr(CLUSTER_ID_BASE, act[ADDR_WIDTH-2:0]);
      end
      CID_A: state_d = CID_D;
      CID_D: begin
        state_d = BAT_A;
        addr_d = idx_addr(BATTERY_BASE, act[ADDR_WIDTH-2:0]);
      end
      BAT_A: state_d = BAT_D;
`ifdef REWARD_QVAL_EN
      BAT_D: begin
        state_d = Q_A;
        addr_d = idx_addr(QVALUE_BASE, act[ADDR_WIDTH-2:0]);
      end
      Q_A: state_d = Q_D;
      Q_D: state_d = CALC;
`else
      BAT_D: state_d = CALC;
`endif
      CALC: begin
        reward_d = (invalid || nbr_id == node_id) ? '0 : sum_reward;
        done_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        load = en;
        state_d = start ? DONE : IDLE;
        done_d = start;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
      address <= '0;
      reward_out <= '0;
      done <= 1'b0;
      invalid <= 1'b0;
      node_id <= '0;
      cluster_id <= '0;
      act <= '0;
      best <= '0;
      nbr_id <= '0;
      nbr_cid <= '0;
      batt <= '0;
`ifdef REWARD_QVAL_EN
      qval <= '0;
`endif
    end else begin
      state <= state_d;
      address <= addr_d;
      reward_out <= reward_d;
      done <= done_d;
      invalid <= invalid_d;
      node_id <= load ? MY_NODE_ID : node_id;
      cluster_id <= load ? MY_CLUSTER_ID : cluster_id;
      act <= load ? action : act;
      best <= load ? besthop : best;
      nbr_id <= state == NID_D ? data_in : nbr_id;
      nbr_cid <= state == CID_D ? data_in : nbr_cid;
      batt <= state == BAT_D ? data_in : batt;
`ifdef REWARD_QVAL_EN
      qval <= state == Q_D ? data_in : qval;
`endif
    end
  end
endmodule

// File: tb/tb_reward_calc.sv
// tb_reward_calc: scoreboard bench for reward_calc with a shared node-state memory model
module tb_reward_calc;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic rst, en, start, s_en, s_start;
  logic [15:0] my_node_id, my_cluster_id, action, besthop;
  logic [15:0] data_in, s_data_in, reward_out, s_reward_out;
  logic [10:0] address, s_address;
  logic done, s_done;
  logic [15:0] mem [0:1023];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [15:0] reward;
    int cyc;
  } exp_t;
  exp_t q_main[$];
  exp_t q_sat[$];
  logic [10:0] q_addr[$];
  exp_t me, se;
  logic mon_on = 1'b0;
  logic done_q = 1'b0;
  logic s_done_q = 1'b0;
  logic [10:0] addr_q = '0;
  reward_calc u_dut (
    .clock(clock), .rst(rst), .en(en), .start(start),
    .MY_NODE_ID(my_node_id), .MY_CLUSTER_ID(my_cluster_id),
    .action(action), .besthop(besthop),
    .address(address), .data_in(data_in),
    .reward_out(reward_out), .done(done)
  );
  reward_calc #(.BATT_SHIFT(0)) u_sat (
    .clock(clock), .rst(rst), .en(s_en), .start(s_start),
    .MY_NODE_ID(my_node_id), .MY_CLUSTER_ID(my_cluster_id),
    .action(action), .besthop(besthop),
    .address(s_address), .data_in(s_data_in),
    .reward_out(s_reward_out), .done(s_done)
  );
  always @(posedge clock) begin
    cyc <= cyc + 1;
    data_in <= mem[address[10:1]];
    s_data_in <= mem[s_address[10:1]];
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask
  always @(negedge clock) begin
    if (done && !done_q) begin
      if (q_main.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL main done: unexpected result %h", reward_out);
      end else begin
        me = q_main.pop_front();
        chk("main reward", reward_out, me.reward);
        chk("main latency", cyc, me.cyc);
      end
    end
    if (s_done && !s_done_q) begin
      if (q_sat.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sat done: unexpected result %h", s_reward_out);
      end else begin
        se = q_sat.pop_front();
        chk("sat reward", s_reward_out, se.reward);
        chk("sat latency", cyc, se.cyc);
      end
    end
    if (mon_on && address !== addr_q) begin
      if (q_addr.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL address: unexpected change to %h", address);
      end else begin
        chk("address seq", address, q_addr.pop_front());
      end
    end
    done_q <= done;
    s_done_q <= s_done;
    addr_q <= address;
  end
  task automatic load(input bit sat, input logic [15:0] act);
    @(negedge clock);
    action = act;
    if (sat) s_en = 1'b1; else en = 1'b1;
    @(negedge clock);
    en = 1'b0;
    s_en = 1'b0;
  endtask
  task automatic push4(input logic [10:0] a0, a1, a2, a3);
    q_addr.push_back(a0);
    q_addr.push_back(a1);
    q_addr.push_back(a2);
    q_addr.push_back(a3);
  endtask
  task automatic run(input bit sat, input logic [15:0] want, input int lat);
    exp_t e;
    e.reward = want;
    e.cyc = cyc + lat;
    if (sat) q_sat.push_back(e); else q_main.push_back(e);
    if (sat) s_start = 1'b1; else start = 1'b1;
    for (int i = 0; i < 40 && !(sat ? s_done : done); i++) @(negedge clock);
    chk("done seen", 32'(sat ? s_done : done), 1);
    repeat (3) @(negedge clock);
    chk("done held", 32'(sat ? s_done : done), 1);
    chk("reward held", 32'(sat ? s_reward_out : reward_out), 32'(want));
    start = 1'b0;
    s_start = 1'b0;
    @(negedge clock);
    chk("done cleared", 32'(sat ? s_done : done), 0);
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[11'h68A >> 1] = 16'd4;
    mem[11'h04C >> 1] = 16'h1234;
    mem[11'h0CC >> 1] = 16'h4888;
    mem[11'h14C >> 1] = 16'h00A0;
    mem[11'h04E >> 1] = 16'h2222;
    mem[11'h0CE >> 1] = 16'h1111;
    mem[11'h14E >> 1] = 16'h0100;
    rst = 1'b1;
    en = 1'b0;
    s_en = 1'b0;
    start = 1'b0;
    s_start = 1'b0;
    my_node_id = 16'hF365;
    my_cluster_id = 16'h4888;
    besthop = 16'd3;
    action = 16'd0;
    repeat (3) @(negedge clock);
    chk("reset reward", reward_out, 0);
    chk("reset done", done, 0);
    chk("reset address", address, 0);
    chk("reset sat reward", s_reward_out, 0);
    chk("reset sat done", s_done, 0);
    rst = 1'b0;
    mon_on = 1'b1;
    push4(11'h68A, 11'h04C, 11'h0CC, 11'h14C);
    load(0, 16'd2);
    run(0, 16'h0028, 10);
    mem[11'h04C >> 1] = 16'hF365;
    push4(11'h68A, 11'h04C, 11'h0CC, 11'h14C);
    run(0, 16'h0000, 10);
    mem[11'h04C >> 1] = 16'h1234;
    push4(11'h68A, 11'h04E, 11'h0CE, 11'h14E);
    load(0, 16'd3);
    run(0, 16'h004C, 10);
    load(0, 16'd2);
    q_addr.push_back(11'h68A);
    q_addr.push_back(11'h04C);
    q_addr.push_back(11'h000);
    start = 1'b1;
    repeat (4) @(negedge clock);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clock);
    rst = 1'b0;
    chk("midrun rst done", done, 0);
    chk("midrun rst reward", reward_out, 0);
    chk("midrun rst address", address, 0);
    load(0, 16'd2);
    push4(11'h68A, 11'h04C, 11'h0CC, 11'h14C);
    run(0, 16'h0028, 10);
    load(0, 16'd4);
    q_addr.push_back(11'h68A);
    run(0, 16'h0000, 4);
    mem[11'h14C >> 1] = 16'hFFFF;
    load(1, 16'd2);
    run(1, 16'hFFFF, 10);
    repeat (3) @(negedge clock);
    chk("scoreboard drained", q_main.size() + q_sat.size() + q_addr.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
